// File: rtl/alu_mdu_if.sv
// Request/response bundle of the M-extension unit.
// The requester takes master, the unit takes slave.
interface alu_mdu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, opcode, funct3, funct7,
        output rs1, rs2, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7,
        input  rs1, rs2, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/alu_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit beside the execute ALU.
// Shift-add multiplier and restoring divider share one 2*XLEN register.
module alu_mdu #(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    output logic     m_sel,
    output logic     busy,
    alu_mdu_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] MUL_N = CW'(XLEN / MUL_UNROLL);
    localparam logic [CW-1:0] DIV_N = CW'(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [6:0] OPC_OP = 7'b011_0011;
    localparam logic [6:0] F7_M   = 7'b000_0001;
    localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [2*XLEN-1:0] p;
    logic [2:0]        op;
    logic              neg;
    logic              spec;
    logic              vld;
    logic [XLEN-1:0]   res;

    logic [2:0]      f3;
    logic            accept;
    logic            sgn_a;
    logic            sgn_b;
    logic            neg_d;
    logic            dz;
    logic            ovf;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] spec_val;

    assign f3            = bus.funct3;
    assign m_sel         = (bus.opcode == OPC_OP) && (bus.funct7 == F7_M);
    assign bus.in_ready  = (state == S_IDLE) && !flush;
    assign accept        = bus.in_valid && bus.in_ready && m_sel;
    assign busy          = (state != S_IDLE);
    assign bus.out_valid = vld;
    assign bus.result    = res;

    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        unique case (f3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn_a = bus.rs1[XLEN-1];
                sgn_b = bus.rs2[XLEN-1];
            end
            3'b010:  sgn_a = bus.rs1[XLEN-1];
            default: ;
        endcase
        mag_a = sgn_a ? -bus.rs1 : bus.rs1;
        mag_b = sgn_b ? -bus.rs2 : bus.rs2;
        // REM follows the dividend; everything else follows the sign xor
        neg_d = (f3 == 3'b110) ? sgn_a : (sgn_a ^ sgn_b);
        dz    = f3[2] && (bus.rs2 == '0);
        ovf   = (f3 == 3'b100 || f3 == 3'b110) &&
                (bus.rs1 == MIN_S) && (bus.rs2 == '1);
        if (dz)
            spec_val = f3[1] ? bus.rs1 : '1;
        else
            spec_val = f3[1] ? '0 : bus.rs1;
    end

    logic [2*XLEN-1:0] mstep;
    logic [2*XLEN-1:0] dstep;
    logic [XLEN-1:0]   madd;
    logic [XLEN:0]     msum;
    logic [XLEN:0]     dt;

    always_comb begin
        mstep = p;
        madd  = '0;
        msum  = '0;
        // low half holds the multiplier, shifted out as the product grows
        for (int i = 0; i < MUL_UNROLL; i++) begin
            madd  = mstep[0] ? a : '0;
            msum  = {1'b0, mstep[2*XLEN-1:XLEN]} + {1'b0, madd};
            mstep = {msum, mstep[XLEN-1:1]};
        end
        dt = {p[2*XLEN-1:XLEN], p[XLEN-1]};
        if (dt >= {1'b0, b})
            dstep = {dt[XLEN-1:0] - b, p[XLEN-2:0], 1'b1};
        else
            dstep = {dt[XLEN-1:0], p[XLEN-2:0], 1'b0};
    end

    logic [2*XLEN-1:0] pn;
    logic [XLEN-1:0]   q_s;
    logic [XLEN-1:0]   r_s;
    logic [XLEN-1:0]   res_d;

    always_comb begin
        pn    = neg ? -p : p;
        q_s   = neg ? -p[XLEN-1:0] : p[XLEN-1:0];
        r_s   = neg ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
        res_d = pn[2*XLEN-1:XLEN];
        unique case (1'b1)
            spec:                          res_d = p[XLEN-1:0];
            !spec && op == 3'b000:         res_d = pn[XLEN-1:0];
            !spec && op[2:1] == 2'b10:     res_d = q_s;
            !spec && op[2:1] == 2'b11:     res_d = r_s;
            default:                       res_d = pn[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
            p     <= '0;
            op    <= '0;
            neg   <= 1'b0;
            spec  <= 1'b0;
            vld   <= 1'b0;
            res   <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            vld   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (accept) begin
                    a    <= mag_a;
                    b    <= mag_b;
                    op   <= f3;
                    neg  <= neg_d;
                    spec <= dz || ovf;
                    if (dz || ovf) begin
                        p     <= {{XLEN{1'b0}}, spec_val};
                        state <= S_DONE;
                    end else if (f3[2]) begin
                        p     <= {{XLEN{1'b0}}, mag_a};
                        cnt   <= DIV_N;
                        state <= S_DIV;
                    end else begin
                        p     <= {{XLEN{1'b0}}, mag_b};
                        cnt   <= MUL_N;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    p   <= mstep;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= S_DONE;
                end
                S_DIV: begin
                    p   <= dstep;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    // first DONE cycle registers the signed result
                    if (!vld) begin
                        res <= res_d;
                        vld <= 1'b1;
                    end else if (bus.out_ready) begin
                        vld   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
